z80_io_uart: RTL and testbench
==============================

Z80_IO_UART -- requirements
Module: z80_io_uart

Interface
REQ-001 Parameter: DATA_PORT, 8'hBB, I/O address of the TX/RX data register.
REQ-002 Parameter: STATUS_PORT, 8'hBC, I/O address of the read-only status register.
REQ-003 Parameter: CLKS_PER_BIT, 16, clk cycles per serial bit, minimum 4, even.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 address  input  8  CPU address bits [7:0].
REQ-007 din  input  8  CPU data-out bus.
REQ-008 iorq_n  input  1  CPU I/O request, active low.
REQ-009 rd_n  input  1  CPU read strobe, active low.
REQ-010 wr_n  input  1  CPU write strobe, active low.
REQ-011 dout  output  8  read data to CPU; 8'h00 when not driving.
REQ-012 dout_en  output  1  high while an I/O read targets DATA_PORT or STATUS_PORT.
REQ-013 s_rx  input  1  serial receive line, asynchronous, idle high.
REQ-014 s_tx  output  1  serial transmit line, idle high.

Function
REQ-015 Write strobe ws = !iorq_n & !wr_n; read strobe rs = !iorq_n & !rd_n; both registered once for edge detection.
REQ-016 Write accepted on first cycle ws high after a cycle low, address == DATA_PORT; writes to other ports ignored.
REQ-017 Accepted write with TX holding register empty: load din, mark full next cycle.
REQ-018 Accepted write with holding register full: data dropped, tx_overrun sticky bit set.
REQ-019 dout_en/dout combinational from rs and address: DATA_PORT -> RX buffer; STATUS_PORT -> status; else dout_en 0, dout 8'h00.
REQ-020 Status byte: bit0 rx_valid, bit1 tx_ready (holding empty), bit2 rx_overrun, bit3 framing_err, bit4 tx_overrun, bit5 tx_busy, bits7:6 0.
REQ-021 Read side effects occur on the cycle rs falls, using address latched at rs rise: DATA_PORT clears rx_valid; STATUS_PORT clears bits 2,3,4.
REQ-022 TX FSM states IDLE, START, DATA, STOP; 8N1 framing, LSB first, each bit exactly CLKS_PER_BIT cycles.
REQ-023 IDLE with holding full: move byte to shift register, clear holding (tx_ready 1 next cycle), enter START, s_tx 0.
REQ-024 DATA: 3-bit index 0..7, then STOP (s_tx 1); after STOP, IDLE; back-to-back byte starts next cycle with no extra idle.
REQ-025 tx_busy high in START, DATA, STOP.
REQ-026 RX: s_rx through 2-flop synchronizer before use.
REQ-027 RX FSM states IDLE, START, DATA, STOP; IDLE -> START on synchronized low.
REQ-028 START: sample at CLKS_PER_BIT/2; high -> IDLE (glitch, no error); low -> DATA.
REQ-029 DATA: sample each bit every CLKS_PER_BIT cycles, LSB first; after bit 7, STOP.
REQ-030 STOP sample high: byte complete; low: set framing_err, discard byte; both return IDLE.
REQ-031 Byte complete with rx_valid 0: load RX buffer, set rx_valid.
REQ-032 Byte complete with rx_valid 1: buffer kept, new byte discarded, rx_overrun set.
REQ-033 Byte complete same cycle as data-read clear: new byte loaded, rx_valid stays 1, no overrun.
REQ-034 Write accepted same cycle TX moves holding to shifter: treated as holding empty; new byte loaded, no overrun.
REQ-035 Sticky bit set and clear in same cycle: set wins.

Reset
REQ-036 Reset: both FSMs IDLE, counters 0, s_tx 1, holding empty, rx_valid 0, all sticky bits 0, RX buffer 8'h00, edge registers 0.
REQ-037 Reset mid-frame aborts TX/RX immediately; s_tx 1 the cycle after reset sampled.

Verification
REQ-038 OUT (0xBB),0x41 -> s_tx: 0, 1,0,0,0,0,0,1,0, 1, each bit 16 clks; tx_busy high 160 clks.
REQ-039 Two OUTs 0x55,0xAA back-to-back -> both frames contiguous; third OUT while holding full -> dropped, status bit4 1.
REQ-040 Drive s_rx frame 0xC3 -> IN (0xBC) = 8'h03 (rx_valid, tx_ready); IN (0xBB) = 0xC3; next status = 8'h02.
REQ-041 Two RX frames 0x11, 0x22 unread -> IN (0xBB) = 0x11, status bit2 1; status read clears it.
REQ-042 RX frame with stop bit 0 -> rx_valid 0, status bit3 1; 4-clk low glitch on s_rx -> no change.
REQ-043 Reset asserted mid-TX bit 3 -> s_tx 1 next cycle, status = 8'h02 after reset.

Source files
------------

// File: rtl/z80_io_uart.sv
// Z80 I/O-mapped UART: one data port (TX holding / RX buffer) and one status port,
// 8N1 framing at CLKS_PER_BIT clocks per bit, timers are down-counters to zero.
//
// TX / RX FSM states (same encoding for both machines)
//   state   | meaning
//   S_IDLE  | line idle; TX waits for holding byte, RX waits for low on synced line
//   S_START | start bit; TX drives 0, RX waits half a bit then re-checks the line
//   S_DATA  | eight data bits, LSB first, one per CLKS_PER_BIT clocks
//   S_STOP  | stop bit; TX drives 1, RX samples it for framing check

module z80_io_uart #(
    parameter logic [7:0] DATA_PORT    = 8'hBB,
    parameter logic [7:0] STATUS_PORT  = 8'hBC,
    parameter int         CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] address,
    input  logic [7:0] din,
    input  logic       iorq_n,
    input  logic       rd_n,
    input  logic       wr_n,
    output logic [7:0] dout,
    output logic       dout_en,
    input  logic       s_rx,
    output logic       s_tx
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    // ---------------- CPU bus strobes ----------------
    logic       ws, rs, ws_q, rs_q;
    logic [7:0] rd_addr_q, rd_addr_d;
    logic       wr_accept, rd_fall, clr_rx_valid, clr_sticky;

    always_comb begin
        ws           = !iorq_n && !wr_n;
        rs           = !iorq_n && !rd_n;
        wr_accept    = ws && !ws_q && (address == DATA_PORT);
        rd_fall      = rs_q && !rs;
        rd_addr_d    = (rs && !rs_q) ? address : rd_addr_q;
        clr_rx_valid = rd_fall && (rd_addr_q == DATA_PORT);
        clr_sticky   = rd_fall && (rd_addr_q == STATUS_PORT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_q      <= 1'b0;
            rs_q      <= 1'b0;
            rd_addr_q <= 8'h00;
        end else begin
            ws_q      <= ws;
            rs_q      <= rs;
            rd_addr_q <= rd_addr_d;
        end
    end

    // ---------------- TX FSM ----------------
    state_t        tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_idx_q, tx_idx_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          tx_ovr_q, tx_ovr_d;
    logic          tx_take, tx_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= 3'd0;
            tx_sh_q    <= 8'h00;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_sh_q    <= tx_sh_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_sh_d    = tx_sh_q;
        case (tx_state_q)
            S_IDLE: ;
            S_START:
                if (tx_cnt_q == '0) begin
                    tx_state_d = S_DATA;
                    tx_cnt_d   = BIT_LAST;
                    tx_idx_d   = 3'd0;
                end else begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end
            S_DATA:
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = BIT_LAST;
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    if (tx_idx_q == 3'd7) tx_state_d = S_STOP;
                    else                  tx_idx_d   = tx_idx_q + 3'd1;
                end else begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end
            S_STOP:
                if (tx_cnt_q == '0) tx_state_d = S_IDLE;
                else                tx_cnt_d   = tx_cnt_q - CW'(1);
        endcase
        // Taking from STOP's last cycle gives back-to-back frames with no idle gap
        if (tx_take) begin
            tx_state_d = S_START;
            tx_cnt_d   = BIT_LAST;
            tx_sh_d    = hold_q;
        end
    end

    always_comb begin
        s_tx    = 1'b1;
        tx_busy = 1'b0;
        tx_take = hold_full_q &&
                  ((tx_state_q == S_IDLE) || ((tx_state_q == S_STOP) && (tx_cnt_q == '0)));
        case (tx_state_q)
            S_IDLE:  ;
            S_START: begin s_tx = 1'b0;       tx_busy = 1'b1; end
            S_DATA:  begin s_tx = tx_sh_q[0]; tx_busy = 1'b1; end
            S_STOP:  tx_busy = 1'b1;
        endcase
    end

    // Holding register: a write landing on the take cycle sees it as empty
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_ovr_d    = tx_ovr_q && !clr_sticky;
        if (wr_accept && (!hold_full_q || tx_take)) begin
            hold_d      = din;
            hold_full_d = 1'b1;
        end else if (wr_accept) begin
            tx_ovr_d = 1'b1;
        end else if (tx_take) begin
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            tx_ovr_q    <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_ovr_q    <= tx_ovr_d;
        end
    end

    // ---------------- RX FSM ----------------
    logic          rx_s1_q, rx_s2_q;
    state_t        rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_idx_q, rx_idx_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic [7:0]    rx_buf_q, rx_buf_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_ovr_q, rx_ovr_d;
    logic          fr_err_q, fr_err_d;
    logic          rx_done, rx_bad_stop;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= 3'd0;
            rx_sh_q    <= 8'h00;
        end else begin
            rx_s1_q    <= s_rx;
            rx_s2_q    <= rx_s1_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_sh_q    <= rx_sh_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_sh_d    = rx_sh_q;
        case (rx_state_q)
            S_IDLE:
                if (!rx_s2_q) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = HALF_LAST;
                end
            S_START:
                if (rx_cnt_q == '0) begin
                    // Line back high at mid start bit is a glitch, not a frame
                    if (rx_s2_q) begin
                        rx_state_d = S_IDLE;
                    end else begin
                        rx_state_d = S_DATA;
                        rx_cnt_d   = BIT_LAST;
                        rx_idx_d   = 3'd0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end
            S_DATA:
                if (rx_cnt_q == '0) begin
                    rx_cnt_d = BIT_LAST;
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
                    else                  rx_idx_d   = rx_idx_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q - CW'(1);
                end
            S_STOP:
                if (rx_cnt_q == '0) rx_state_d = S_IDLE;
                else                rx_cnt_d   = rx_cnt_q - CW'(1);
        endcase
    end

    always_comb begin
        rx_done     = (rx_state_q == S_STOP) && (rx_cnt_q == '0) && rx_s2_q;
        rx_bad_stop = (rx_state_q == S_STOP) && (rx_cnt_q == '0) && !rx_s2_q;
    end

    always_comb begin
        rx_buf_d   = rx_buf_q;
        rx_valid_d = rx_valid_q;
        rx_ovr_d   = rx_ovr_q && !clr_sticky;
        fr_err_d   = rx_bad_stop || (fr_err_q && !clr_sticky);
        if (rx_done && (!rx_valid_q || clr_rx_valid)) begin
            rx_buf_d   = rx_sh_q;
            rx_valid_d = 1'b1;
        end else if (rx_done) begin
            rx_ovr_d = 1'b1;
        end else if (clr_rx_valid) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_buf_q   <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
            fr_err_q   <= 1'b0;
        end else begin
            rx_buf_q   <= rx_buf_d;
            rx_valid_q <= rx_valid_d;
            rx_ovr_q   <= rx_ovr_d;
            fr_err_q   <= fr_err_d;
        end
    end

    // ---------------- read mux ----------------
    always_comb begin
        dout_en = 1'b0;
        dout    = 8'h00;
        if (rs && (address == DATA_PORT)) begin
            dout_en = 1'b1;
            dout    = rx_buf_q;
        end else if (rs && (address == STATUS_PORT)) begin
            dout_en = 1'b1;
            dout    = {2'b00, tx_busy, tx_ovr_q, fr_err_q, rx_ovr_q, !hold_full_q, rx_valid_q};
        end
    end

endmodule

// File: tb/tb_z80_io_uart.sv
// Directed and randomized bench for z80_io_uart; a high-level model tracks the
// status flags and RX buffer, TX output is compared against ideal 8N1 waveforms.
module tb_z80_io_uart;

    localparam logic [7:0] DP = 8'hBB;
    localparam logic [7:0] SP = 8'hBC;

    logic       clk;
    logic       reset;
    logic [7:0] address;
    logic [7:0] din;
    logic       iorq_n, rd_n, wr_n;
    logic [7:0] dout;
    logic       dout_en;
    logic       s_rx;
    logic       s_tx;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         c0;
    logic       s_log[$];
    logic [7:0] exp_q[$];
    logic [7:0] rdv;
    logic       rde;

    // reference model state
    logic       m_valid, m_rxovr, m_fr, m_txovr;
    logic [7:0] m_buf;

    z80_io_uart #(.DATA_PORT(DP), .STATUS_PORT(SP), .CLKS_PER_BIT(16)) dut (
        .clk(clk), .reset(reset), .address(address), .din(din),
        .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .dout(dout), .dout_en(dout_en), .s_rx(s_rx), .s_tx(s_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) s_log.push_back(s_tx);

    initial begin
        #3000000;
        $display("FAIL watchdog: observed no completion, expected finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int seg);
        if (seg == 0) return 1'b0;
        if (seg <= 8) return b[seg-1];
        return 1'b1;
    endfunction

    function automatic logic [7:0] m_status();
        return {2'b00, 1'b0, m_txovr, m_fr, m_rxovr, 1'b1, m_valid};
    endfunction

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        address = a; din = d; iorq_n = 1'b0; wr_n = 1'b0;
        @(negedge clk); @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic io_read(input logic [7:0] a, output logic [7:0] d, output logic en);
        address = a; iorq_n = 1'b0; rd_n = 1'b0;
        #1;
        d = dout; en = dout_en;
        @(negedge clk); @(negedge clk);
        iorq_n = 1'b1; rd_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [7:0] expv, input string tag);
        logic [7:0] d;
        logic       en;
        io_read(a, d, en);
        chk(tag, d, expv);
        chk({tag, "_en"}, en, 1'b1);
    endtask

    task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
        s_rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            s_rx = b[i];
            repeat (16) @(negedge clk);
        end
        s_rx = stop_bit;
        repeat (16) @(negedge clk);
        s_rx = 1'b1;
        repeat (24) @(negedge clk);
    endtask

    task automatic glitch(input int len);
        s_rx = 1'b0;
        repeat (len) @(negedge clk);
        s_rx = 1'b1;
        repeat (30) @(negedge clk);
    endtask

    // Compare the logged line against contiguous ideal frames for exp_q, then idle
    task automatic check_tx_log(input string tag);
        int             i0, idx;
        logic [159:0]   obs, expv;
        logic [15:0]    idle;
        i0 = -1;
        for (int i = 0; i < s_log.size(); i++)
            if (i0 < 0 && s_log[i] == 1'b0) i0 = i;
        chk({tag, "_start"}, (i0 >= 0), 1'b1);
        if (i0 < 0) i0 = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            for (int c = 0; c < 160; c++) begin
                idx     = i0 + 160 * k + c;
                obs[c]  = (idx < s_log.size()) ? s_log[idx] : 1'bx;
                expv[c] = frame_bit(exp_q[k], c / 16);
            end
            chk($sformatf("%s_frame%0d", tag, k), obs, expv);
        end
        for (int c = 0; c < 16; c++) begin
            idx     = i0 + 160 * exp_q.size() + c;
            idle[c] = (idx < s_log.size()) ? s_log[idx] : 1'bx;
        end
        chk({tag, "_idle_after"}, idle, 16'hFFFF);
    endtask

    task automatic count_low(output int n);
        n = 0;
        for (int i = 0; i < s_log.size(); i++) if (s_log[i] !== 1'b1) n++;
    endtask

    initial begin
        int         sel, nlow;
        logic [7:0] b;

        reset = 1'b1; address = 8'h00; din = 8'h00;
        iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; s_rx = 1'b1;
        repeat (3) @(negedge clk);

        // reset state visible through the combinational read path
        chk("rst_s_tx", s_tx, 1'b1);
        chk("rst_idle_dout_en", dout_en, 1'b0);
        address = SP; iorq_n = 1'b0; rd_n = 1'b0; #1;
        chk("rst_status", dout, 8'h02);
        iorq_n = 1'b1; rd_n = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        rd_chk(DP, 8'h00, "rst_rx_buf");
        address = 8'h10; iorq_n = 1'b0; rd_n = 1'b0; #1;
        chk("other_port_en", dout_en, 1'b0);
        chk("other_port_dout", dout, 8'h00);
        iorq_n = 1'b1; rd_n = 1'b1;
        @(negedge clk);

        // write to status port must not start a transmission
        s_log.delete();
        io_write(SP, 8'h5A);
        rd_chk(SP, 8'h02, "wr_status_ignored");
        repeat (20) @(negedge clk);
        count_low(nlow);
        chk("wr_status_no_tx", nlow, 0);

        // single byte 0x41, busy exactly 160 clocks
        exp_q.delete(); exp_q.push_back(8'h41);
        s_log.delete();
        c0 = cyc;
        io_write(DP, 8'h41);
        while (cyc < c0 + 50) @(negedge clk);
        rd_chk(SP, 8'h22, "tx41_mid_status");
        while (cyc < c0 + 161) @(negedge clk);
        address = SP; iorq_n = 1'b0; rd_n = 1'b0; #1;
        chk("tx41_busy_last", dout, 8'h22);
        @(negedge clk); #1;
        chk("tx41_busy_end", dout, 8'h02);
        iorq_n = 1'b1; rd_n = 1'b1;
        repeat (40) @(negedge clk);
        check_tx_log("tx41");
        rd_chk(SP, 8'h02, "tx41_done_status");

        // back-to-back, drop while full, then write exactly on the take cycle
        exp_q.delete(); exp_q.push_back(8'h55); exp_q.push_back(8'hAA); exp_q.push_back(8'h3C);
        s_log.delete();
        c0 = cyc;
        io_write(DP, 8'h55);
        io_write(DP, 8'hAA);
        io_write(DP, 8'h33);
        rd_chk(SP, 8'h30, "tx_drop_status");
        rd_chk(SP, 8'h20, "tx_ovr_cleared");
        while (cyc < c0 + 161) @(negedge clk);
        io_write(DP, 8'h3C);
        rd_chk(SP, 8'h20, "tx_take_same_cycle");
        while (cyc < c0 + 520) @(negedge clk);
        check_tx_log("tx_b2b");
        rd_chk(SP, 8'h02, "tx_b2b_done");

        // receive 0xC3
        drive_rx(8'hC3, 1'b1);
        rd_chk(SP, 8'h03, "rxC3_status");
        rd_chk(DP, 8'hC3, "rxC3_data");
        rd_chk(SP, 8'h02, "rxC3_after");

        // overrun
        drive_rx(8'h11, 1'b1);
        drive_rx(8'h22, 1'b1);
        rd_chk(DP, 8'h11, "rx_ovr_data");
        rd_chk(SP, 8'h06, "rx_ovr_status");
        rd_chk(SP, 8'h02, "rx_ovr_cleared");

        // framing error, then a short glitch
        drive_rx(8'h96, 1'b0);
        rd_chk(SP, 8'h0A, "rx_frame_err");
        glitch(4);
        rd_chk(SP, 8'h02, "rx_glitch_status");
        rd_chk(DP, 8'h11, "rx_buf_kept");

        // byte completes on the same cycle as the data-read clear
        drive_rx(8'h5A, 1'b1);
        fork
            drive_rx(8'hE7, 1'b1);
            begin
                repeat (152) @(negedge clk);
                io_read(DP, rdv, rde);
            end
        join
        chk("rx_clr_race_old", rdv, 8'h5A);
        rd_chk(SP, 8'h03, "rx_clr_race_status");
        rd_chk(DP, 8'hE7, "rx_clr_race_new");
        rd_chk(SP, 8'h02, "rx_clr_race_after");

        // reset mid bit 3 of 0x41 with an unread RX byte pending
        drive_rx(8'h96, 1'b1);
        c0 = cyc;
        io_write(DP, 8'h41);
        while (cyc < c0 + 73) @(negedge clk);
        chk("tx_bit3_low", s_tx, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("tx_after_reset", s_tx, 1'b1);
        s_log.delete();
        repeat (200) @(negedge clk);
        count_low(nlow);
        chk("tx_abort_idle", nlow, 0);
        rd_chk(SP, 8'h02, "reset_status");
        rd_chk(DP, 8'h00, "reset_rx_buf");

        // randomized traffic against the model
        m_valid = 1'b0; m_rxovr = 1'b0; m_fr = 1'b0; m_txovr = 1'b0; m_buf = 8'h00;
        for (int it = 0; it < 12; it++) begin
            sel = $urandom_range(0, 3);
            b   = 8'($urandom_range(0, 255));
            case (sel)
                0: begin
                    exp_q.delete(); exp_q.push_back(b);
                    s_log.delete();
                    io_write(DP, b);
                    repeat (185) @(negedge clk);
                    check_tx_log($sformatf("rnd%0d_tx", it));
                end
                1: begin
                    drive_rx(b, 1'b1);
                    if (m_valid) m_rxovr = 1'b1;
                    else begin m_buf = b; m_valid = 1'b1; end
                end
                2: begin
                    drive_rx(b, 1'b0);
                    m_fr = 1'b1;
                end
                default: glitch($urandom_range(1, 5));
            endcase
            if ($urandom_range(0, 1) == 1) begin
                rd_chk(DP, m_buf, $sformatf("rnd%0d_data", it));
                m_valid = 1'b0;
            end
            rd_chk(SP, m_status(), $sformatf("rnd%0d_status", it));
            m_rxovr = 1'b0; m_fr = 1'b0; m_txovr = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
